exc_ctrl: RTL



---
 rtl/exc_pkg.sv | 53 +++++
 rtl/exc_ctrl_if.sv | 28 ++
 rtl/exc_prio_enc.sv | 54 +++++
 rtl/exc_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared constants and types for the exception controller
package exc_pkg;

  // Bit positions inside mem_exc
  localparam int IF_ADEL   = 0;
  localparam int IF_REFILL = 1;
  localparam int IF_INV    = 2;
  localparam int RI        = 3;
  localparam int SYS       = 4;
  localparam int BP        = 5;
  localparam int OV        = 6;
  localparam int D_ADEL    = 7;
  localparam int D_ADES    = 8;
  localparam int D_REFILL  = 9;
  localparam int D_INV     = 10;
  localparam int MOD       = 11;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] OFS_REFILL  = 32'h0000_0000;
  localparam logic [31:0] OFS_GENERAL = 32'h0000_0180;
  localparam logic [31:0] OFS_INT     = 32'h0000_0200;
  localparam logic [31:0] OFS_BEV     = 32'h0000_0200;

  typedef struct packed {
    logic       hit;
    logic [4:0] code;
    logic       is_if;
    logic       is_tlb;
    logic       is_refill;
    logic       badv;
  } prio_t;

  function automatic logic [31:0] vec_offset(input prio_t p, input logic in_exl,
                                             input logic special_int_vec);
    if (p.is_refill && !in_exl)
      return OFS_REFILL;
    else if (p.code == EXC_INT && special_int_vec)
      return OFS_INT;
    else
      return OFS_GENERAL;
  endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// rtl/exc_ctrl_if.sv - CP0 update strobe and fetch redirect handshake
interface exc_ctrl_if;
  logic        en_exp_o;
  logic [31:0] exp_epc;
  logic        exp_bd;
  logic [4:0]  exp_code;
  logic [31:0] exp_bad_vaddr;
  logic        exp_badv_we;
  logic [7:0]  exp_asid;
  logic        exp_asid_we;
  logic        clean_exl;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (
    output en_exp_o, exp_epc, exp_bd, exp_code, exp_bad_vaddr, exp_badv_we,
           exp_asid, exp_asid_we, clean_exl, flush, redirect_valid, redirect_pc,
    input  redirect_ready
  );

  modport slave (
    input  en_exp_o, exp_epc, exp_bd, exp_code, exp_bad_vaddr, exp_badv_we,
           exp_asid, exp_asid_we, clean_exl, flush, redirect_valid, redirect_pc,
    output redirect_ready
  );
endinterface

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - fixed-priority encoder over interrupt and exception flags
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic        irq,
  input  logic [11:0] exc,
  input  logic        is_store,
  output prio_t       res
);

  always_comb begin
    res     = '0;
    res.hit = 1'b1;
    if (irq) begin
      res.code = EXC_INT;
    end else if (exc[IF_ADEL]) begin
      res.code  = EXC_ADEL;
      res.is_if = 1'b1;
      res.badv  = 1'b1;
    end else if (exc[IF_REFILL] || exc[IF_INV]) begin
      res.code      = EXC_TLBL;
      res.is_if     = 1'b1;
      res.is_tlb    = 1'b1;
      res.is_refill = exc[IF_REFILL];
      res.badv      = 1'b1;
    end else if (exc[RI]) begin
      res.code = EXC_RI;
    end else if (exc[SYS]) begin
      res.code = EXC_SYS;
    end else if (exc[BP]) begin
      res.code = EXC_BP;
    end else if (exc[OV]) begin
      res.code = EXC_OV;
    end else if (exc[D_ADEL]) begin
      res.code = EXC_ADEL;
      res.badv = 1'b1;
    end else if (exc[D_ADES]) begin
      res.code = EXC_ADES;
      res.badv = 1'b1;
    end else if (exc[D_REFILL] || exc[D_INV]) begin
      res.code      = is_store ? EXC_TLBS : EXC_TLBL;
      res.is_tlb    = 1'b1;
      res.is_refill = exc[D_REFILL];
      res.badv      = 1'b1;
    end else if (exc[MOD]) begin
      res.code   = EXC_MOD;
      res.is_tlb = 1'b1;
      res.badv   = 1'b1;
    end else begin
      res.hit = 1'b0;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - precise exception controller at commit; EXC_IRQ_SYNC_EN adds a 2-flop hardware_int synchronizer
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_bd,
  input  logic [11:0] mem_exc,
  input  logic        mem_is_store,
  input  logic [31:0] mem_if_vaddr,
  input  logic [31:0] mem_d_vaddr,
  input  logic        mem_eret,
  input  logic [5:0]  hardware_int,
  input  logic        timer_int,
  input  logic [1:0]  software_int,
  input  logic [7:0]  interrupt_mask,
  input  logic        allow_int,
  input  logic        in_exl,
  input  logic        special_int_vec,
  input  logic        boot_exp_vec,
  input  logic [19:0] ebase,
  input  logic [31:0] epc,
  input  logic [7:0]  asid,
  exc_ctrl_if.master  cp0
);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_REDIRECT = 1'b1;

  logic [5:0] hw_s;

`ifdef EXC_IRQ_SYNC_EN
  logic [11:0] sync_d, sync_q;

  always_comb sync_d = {sync_q[5:0], hardware_int};

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign hw_s = sync_q[11:6];
`else
  assign hw_s = hardware_int;
`endif

  logic [7:0] ip;
  logic       irq;
  prio_t      pr;

  assign ip  = {hw_s[5] | timer_int, hw_s[4:0], software_int};
  assign irq = allow_int & ~in_exl & (|(ip & interrupt_mask));

  exc_prio_enc u_prio (
    .irq      (irq),
    .exc      (mem_exc),
    .is_store (mem_is_store),
    .res      (pr)
  );

  logic [31:0] vec_base, vec_pc;
  assign vec_base = boot_exp_vec ? (RESET_VEC + OFS_BEV) : {ebase, 12'h000};
  assign vec_pc   = vec_base + vec_offset(pr, in_exl, special_int_vec);

  logic [0:0]  state_d, state_q;
  logic        en_exp_d, en_exp_q;
  logic [31:0] epc_d, epc_q;
  logic        bd_d, bd_q;
  logic [4:0]  code_d, code_q;
  logic [31:0] badv_d, badv_q;
  logic        badv_we_d, badv_we_q;
  logic [7:0]  asid_d, asid_q;
  logic        asid_we_d, asid_we_q;
  logic        clean_exl_d, clean_exl_q;
  logic        flush_d, flush_q;
  logic        rv_d, rv_q;
  logic [31:0] rpc_d, rpc_q;

  always_comb begin
    state_d     = state_q;
    en_exp_d    = 1'b0;
    clean_exl_d = 1'b0;
    badv_we_d   = 1'b0;
    asid_we_d   = 1'b0;
    epc_d       = epc_q;
    bd_d        = bd_q;
    code_d      = code_q;
    badv_d      = badv_q;
    asid_d      = asid_q;
    flush_d     = flush_q;
    rv_d        = rv_q;
    rpc_d       = rpc_q;
    case (state_q)
      S_IDLE: begin
        if (mem_valid && pr.hit) begin
          en_exp_d  = 1'b1;
          epc_d     = mem_bd ? (mem_pc - 32'd4) : mem_pc;
          bd_d      = mem_bd;
          code_d    = pr.code;
          badv_d    = pr.is_if ? mem_if_vaddr : mem_d_vaddr;
          badv_we_d = pr.badv;
          asid_d    = asid;
          asid_we_d = pr.is_tlb;
          flush_d   = 1'b1;
          rv_d      = 1'b1;
          rpc_d     = vec_pc;
          state_d   = S_REDIRECT;
        end else if (mem_valid && mem_eret) begin
          clean_exl_d = 1'b1;
          flush_d     = 1'b1;
          rv_d        = 1'b1;
          rpc_d       = epc;
          state_d     = S_REDIRECT;
        end
      end
      S_REDIRECT: begin
        // Commit inputs are ignored here; only the fetch handshake matters
        if (rv_q && cp0.redirect_ready) begin
          flush_d = 1'b0;
          rv_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      en_exp_q    <= 1'b0;
      epc_q       <= '0;
      bd_q        <= 1'b0;
      code_q      <= '0;
      badv_q      <= '0;
      badv_we_q   <= 1'b0;
      asid_q      <= '0;
      asid_we_q   <= 1'b0;
      clean_exl_q <= 1'b0;
      flush_q     <= 1'b0;
      rv_q        <= 1'b0;
      rpc_q       <= '0;
    end else begin
      state_q     <= state_d;
      en_exp_q    <= en_exp_d;
      epc_q       <= epc_d;
      bd_q        <= bd_d;
      code_q      <= code_d;
      badv_q      <= badv_d;
      badv_we_q   <= badv_we_d;
      asid_q      <= asid_d;
      asid_we_q   <= asid_we_d;
      clean_exl_q <= clean_exl_d;
      flush_q     <= flush_d;
      rv_q        <= rv_d;
      rpc_q       <= rpc_d;
    end
  end

  assign cp0.en_exp_o       = en_exp_q;
  assign cp0.exp_epc        = epc_q;
  assign cp0.exp_bd         = bd_q;
  assign cp0.exp_code       = code_q;
  assign cp0.exp_bad_vaddr  = badv_q;
  assign cp0.exp_badv_we    = badv_we_q;
  assign cp0.exp_asid       = asid_q;
  assign cp0.exp_asid_we    = asid_we_q;
  assign cp0.clean_exl      = clean_exl_q;
  assign cp0.flush          = flush_q;
  assign cp0.redirect_valid = rv_q;
  assign cp0.redirect_pc    = rpc_q;

endmodule
